// File: rtl/instr_fetch_unit_pkg.sv
// Package: instr_fetch_unit_pkg
// Purpose: shared definitions for the fetch stage of the 16-bit CPU -- default widths,
//          reset/step constants, opcode encodings, fetch FSM state encoding and an
//          opcode-extraction helper.
// Ports:   none (package).
package instr_fetch_unit_pkg;

   localparam int IFU_ADDR_W  = 16;
   localparam int IFU_INSTR_W = 16;

   localparam logic [15:0] IFU_RESET_PC = 16'h0000;
   localparam logic [15:0] IFU_PC_STEP  = 16'h0002;

   // Opcode encodings (instr[15:12])
   localparam logic [3:0] OP_RTYPE = 4'b0110;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_LS    = 4'b0010;
   localparam logic [3:0] OP_SS    = 4'b0011;
   localparam logic [3:0] OP_BEQ   = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

   // Opcode field of a 16-bit instruction word.
   function automatic logic [3:0] opcode_of(input logic [15:0] instr);
      return instr[15:12];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_ifid_reg.sv
// Module: instr_fetch_unit_ifid_reg
// Purpose: single-entry IF/ID pipeline register (valid, instruction, pc).
//          load has priority over clear; with neither, the entry holds.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture load_instr/load_pc and set valid
//   clear               drop valid (instr/pc keep their last value)
//   load_instr, load_pc data captured on load
//   valid, instr, pc    registered contents
module instr_fetch_unit_ifid_reg #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [ADDR_W-1:0]  load_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   // IF/ID entry: load, clear or hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (clear) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
         instr <= instr;
         pc    <= pc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Module: instr_fetch_unit
// Purpose: fetch stage -- owns the PC, fetches over a req/ack instruction-memory
//          handshake into a single-entry IF/ID register. Handles stall, taken-branch
//          redirect (draining an in-flight fetch first) and halt.
// Ports:
//   Clock, Reset_n        rising-edge clock, asynchronous active-low reset
//   ImemReq/ImemAddr      fetch request and byte address (stable until ImemAck)
//   ImemAck/ImemData      fetch completion and fetched word
//   Stall                 downstream cannot consume IF/ID this cycle
//   BranchTaken/Target    one-cycle redirect from execute
//   IfIdValid/Instr/PC    IF/ID register contents
//   OPCODE                IfIdInstr[15:12] (meaningful only with IfIdValid)
//   Halted                fetch stopped on the halt opcode
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W      = IFU_ADDR_W,
   parameter int                INSTR_W     = IFU_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = IFU_RESET_PC,
   parameter logic [ADDR_W-1:0] PC_STEP     = IFU_PC_STEP,
   parameter logic [3:0]        HALT_OPCODE = OP_HALT
)(
   input  logic               Clock,
   input  logic               Reset_n,
   output logic               ImemReq,
   output logic [ADDR_W-1:0]  ImemAddr,
   input  logic               ImemAck,
   input  logic [INSTR_W-1:0] ImemData,
   input  logic               Stall,
   input  logic               BranchTaken,
   input  logic [ADDR_W-1:0]  BranchTarget,
   output logic               IfIdValid,
   output logic [INSTR_W-1:0] IfIdInstr,
   output logic [ADDR_W-1:0]  IfIdPC,
   output logic [3:0]         OPCODE,
   output logic               Halted
);

   fetch_state_e      state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] saved_target_r;
   logic              halted_r;

   logic req_s;
   logic ack_s;
   logic consume_s;
   logic ifid_load_s;
   logic ifid_clear_s;

   // Request generation and IF/ID load/clear decisions.
   // In FETCH the request is withheld only while a full IF/ID is stalled, so an
   // issued request can never be withdrawn before its ack.
   always_comb begin
      req_s        = 1'b0;
      ifid_load_s  = 1'b0;
      ifid_clear_s = 1'b0;
      case (state_r)
         ST_FETCH: req_s = !(IfIdValid && Stall);
         ST_DRAIN: req_s = 1'b1;
         default:  req_s = 1'b0;
      endcase
      ack_s     = ImemAck && req_s;
      consume_s = IfIdValid && !Stall;
      if (BranchTaken) begin
         // Redirect squashes whatever IF/ID holds, including same-cycle ack data.
         ifid_clear_s = 1'b1;
      end else if ((state_r == ST_FETCH) && ack_s) begin
         ifid_load_s = 1'b1;
      end else if (consume_s) begin
         ifid_clear_s = 1'b1;
      end else begin
         ifid_clear_s = 1'b0;
      end
   end

   // Fetch FSM: PC, saved redirect target, state and halt flag
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r        <= ST_BOOT;
         pc_r           <= RESET_PC;
         saved_target_r <= '0;
         halted_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               if (BranchTaken) begin
                  pc_r <= BranchTarget;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (BranchTaken) begin
                  if (ack_s || !req_s) begin
                     pc_r <= BranchTarget;
                  end else begin
                     // Request in flight: keep address stable, redirect after its ack.
                     saved_target_r <= BranchTarget;
                     state_r        <= ST_DRAIN;
                  end
               end else if (ack_s) begin
                  pc_r <= pc_r + PC_STEP;
                  if (ImemData[15:12] == HALT_OPCODE) begin
                     state_r  <= ST_HALTED;
                     halted_r <= 1'b1;
                  end else begin
                     state_r <= ST_FETCH;
                  end
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (BranchTaken) begin
                  saved_target_r <= BranchTarget;
                  if (ack_s) begin
                     pc_r    <= BranchTarget;
                     state_r <= ST_FETCH;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end else if (ack_s) begin
                  pc_r    <= saved_target_r;
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_HALTED: begin
               if (BranchTaken) begin
                  pc_r     <= BranchTarget;
                  halted_r <= 1'b0;
                  state_r  <= ST_FETCH;
               end else begin
                  state_r <= ST_HALTED;
               end
            end
            default: begin
               state_r  <= ST_BOOT;
               halted_r <= 1'b0;
            end
         endcase
      end
   end

   instr_fetch_unit_ifid_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_ifid_reg (
      .clk        (Clock),
      .rst_n      (Reset_n),
      .load       (ifid_load_s),
      .clear      (ifid_clear_s),
      .load_instr (ImemData),
      .load_pc    (pc_r),
      .valid      (IfIdValid),
      .instr      (IfIdInstr),
      .pc         (IfIdPC)
   );

   assign ImemReq  = req_s;
   assign ImemAddr = pc_r;
   assign OPCODE   = opcode_of(IfIdInstr[15:0]);
   assign Halted   = halted_r;

endmodule
